fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage with a decoupling instruction queue. It owns the fetch PC and drives the single-cycle-latency instruction SRAM. Returned words are buffered with their PC in a DEPTH-entry FIFO and delivered to decode over a valid/ready handshake. Branch redirects and exception flushes discard all queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_queue_stage.sv | 115 +++++++++++
 tb/tb_fetch_queue_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: reset vector default, PC step, queue entry layout.
package fetch_pkg;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'hbfc00000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry instruction queue with synchronous clear, count and registered-array head.
// Latency: a push is visible at the head on the following cycle; no bypass.
// Backpressure: caller must not push when full; pop only when count is non-zero.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_dat,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ENTRY_W-1:0]       head
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= push_dat;
    end

    assign head = mem[rptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Purpose: fetch PC owner + SRAM request issue + decoupling queue to decode (FETCH_ADEL_EN adds misaligned-fetch trap/halt).
// Latency: request at t, SRAM data captured at t+1, head valid at t+2; redirects kill queue and in-flight word.
// Backpressure: id_ready low fills the queue, then issue stops until a slot (including a same-cycle pop) frees.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]    fetch_pc;
    logic [31:0]    inflight_pc;
    logic           inflight;
    logic           inflight_adel;
    logic           halted;
    logic           misaligned;
    logic           redirect;
    logic           issue;
    logic           push;
    logic           pop;
    logic           head_vis;
    logic [CW-1:0]  count;
    logic [CW:0]    occupancy;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;
    logic [ENTRY_W-1:0] head_dat;

    assign redirect = flush | br_valid;
    assign head_vis = (count != '0);
    assign id_valid = head_vis & ~redirect;
    assign pop      = id_valid & id_ready;

    // Slots committed = queued + the word still coming back - what leaves this cycle.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue     = resetn & ~redirect & ~halted & (occupancy < DEPTH_C);

    assign inst_sram_en   = issue & ~misaligned;
    assign inst_sram_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc      <= RESET_VEC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            inflight_adel <= 1'b0;
        end else begin
            if (flush)         fetch_pc <= flush_pc;
            else if (br_valid) fetch_pc <= br_target;
            else if (issue)    fetch_pc <= fetch_pc + PC_STEP;
            inflight <= issue;
            if (issue) begin
                inflight_pc   <= fetch_pc;
                inflight_adel <= misaligned;
            end
        end
    end

    // A trapped fetch rides the in-flight slot so it stays ordered behind the previous word.
    assign push            = inflight & ~redirect;
    assign push_entry.pc   = inflight_pc;
    assign push_entry.inst = inflight_adel ? 32'h0 : inst_sram_rdata;
    assign push_entry.adel = inflight_adel;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (redirect),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .count    (count),
        .head     (head_dat)
    );

    assign head    = fetch_entry_t'(head_dat);
    assign id_pc   = head_vis ? head.pc   : 32'h0;
    assign id_inst = head_vis ? head.inst : 32'h0;

`ifdef FETCH_ADEL_EN
    assign misaligned = |fetch_pc[1:0];
    assign id_adel    = head_vis & head.adel;

    always_ff @(posedge clk) begin
        if (!resetn || redirect) halted <= 1'b0;
        else if (issue && misaligned) halted <= 1'b1;
    end
`else
    logic unused_adel;
    assign unused_adel = head.adel;
    assign misaligned  = 1'b0;
    assign halted      = 1'b0;
    assign id_adel     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: scoreboard of issued PCs checked against every decode handshake, plus per-scenario checks.
module tb_fetch_queue_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'hbfc00000;

    logic        clk             = 1'b0;
    logic        resetn          = 1'b0;
    logic        flush           = 1'b0;
    logic [31:0] flush_pc        = '0;
    logic        br_valid        = 1'b0;
    logic [31:0] br_target       = '0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;
    logic        id_valid;
    logic        id_ready        = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_pc_q[$];

    fetch_queue_stage #(
        .RESET_VEC (RVEC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_adel         (id_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Single-cycle SRAM: data for this cycle's request appears next cycle.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!resetn || flush || br_valid) begin
                exp_pc_q.delete();
            end else begin
                if (id_valid && id_ready) begin
                    checks++;
                    if (exp_pc_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_underflow: delivered pc %h, expected no delivery", id_pc);
                    end else begin
                        e = exp_pc_q.pop_front();
                        if (id_pc !== e || id_inst !== sram_word(e) || id_adel !== 1'b0) begin
                            fails++;
                            $display("FAIL sb_head: got pc %h inst %h adel %b, expected pc %h inst %h adel 0",
                                     id_pc, id_inst, id_adel, e, sram_word(e));
                        end
                    end
                end
                if (inst_sram_en) exp_pc_q.push_back(inst_sram_addr);
                checks++;
                if (exp_pc_q.size() > DEPTH) begin
                    fails++;
                    $display("FAIL sb_overfill: %0d outstanding, limit %0d", exp_pc_q.size(), DEPTH);
                end
            end
        end
    endtask

    task automatic do_reset(input logic rdy);
        resetn   = 1'b0;
        flush    = 1'b0;
        br_valid = 1'b0;
        id_ready = rdy;
        repeat (3) step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        id_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({inst_sram_en, id_valid, id_adel} !== 3'b000) begin
            fails++; $display("FAIL rst_ctrl: en/valid/adel %b, expected 000", {inst_sram_en, id_valid, id_adel});
        end
        checks++;
        if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
            fails++; $display("FAIL rst_head: pc %h inst %h, expected 0 0", id_pc, id_inst);
        end
        checks++;
        if (inst_sram_addr !== RVEC) begin
            fails++; $display("FAIL rst_pc: addr %h, expected %h", inst_sram_addr, RVEC);
        end
        step();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst_sram_en, id_valid} !== 2'b10 || inst_sram_addr !== RVEC) begin
            fails++; $display("FAIL rel_c0: en/valid %b addr %h, expected 10 %h", {inst_sram_en, id_valid}, inst_sram_addr, RVEC);
        end
        step(); @(negedge clk);
        checks++;
        if ({inst_sram_en, id_valid} !== 2'b10 || inst_sram_addr !== RVEC + 32'd4) begin
            fails++; $display("FAIL rel_c1: en/valid %b addr %h, expected 10 %h", {inst_sram_en, id_valid}, inst_sram_addr, RVEC + 32'd4);
        end
        step(); @(negedge clk);
        checks++;
        if ({inst_sram_en, id_valid} !== 2'b11 || inst_sram_addr !== RVEC + 32'd8 || id_pc !== RVEC) begin
            fails++; $display("FAIL rel_c2: en/valid %b addr %h pc %h, expected 11 %h %h",
                              {inst_sram_en, id_valid}, inst_sram_addr, id_pc, RVEC + 32'd8, RVEC);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        repeat (8) begin
            step(); @(negedge clk);
            if (id_valid && inst_sram_en) n++;
        end
        checks++;
        if (n != 8) begin
            fails++; $display("FAIL b2b: %0d full-rate cycles, expected 8", n);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset(1'b0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (inst_sram_en) n++;
            step();
        end
        @(negedge clk);
        checks++;
        if (n != DEPTH || inst_sram_en !== 1'b0) begin
            fails++; $display("FAIL bp_fill: %0d requests en %b, expected %0d 0", n, inst_sram_en, DEPTH);
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== RVEC) begin
            fails++; $display("FAIL bp_head: valid %b pc %h, expected 1 %h", id_valid, id_pc, RVEC);
        end
        step();
        id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== RVEC + 32'd16) begin
            fails++; $display("FAIL bp_resume: en %b addr %h, expected 1 %h", inst_sram_en, inst_sram_addr, RVEC + 32'd16);
        end
        repeat (8) step();
    endtask

    task automatic test_branch();
        do_reset(1'b0);
        repeat (4) step();
        br_valid  = 1'b1;
        br_target = 32'hbfc00100;
        @(negedge clk);
        checks++;
        if ({inst_sram_en, id_valid} !== 2'b00) begin
            fails++; $display("FAIL br_cycle: en/valid %b, expected 00", {inst_sram_en, id_valid});
        end
        step();
        br_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00100) begin
            fails++; $display("FAIL br_req: en %b addr %h, expected 1 bfc00100", inst_sram_en, inst_sram_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (id_valid !== 1'b0) begin
            fails++; $display("FAIL br_gap: valid %b, expected 0", id_valid);
        end
        step();
        id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hbfc00100 || id_inst !== sram_word(32'hbfc00100)) begin
            fails++; $display("FAIL br_head: valid %b pc %h inst %h, expected 1 bfc00100 %h",
                              id_valid, id_pc, id_inst, sram_word(32'hbfc00100));
        end
        repeat (6) step();
    endtask

    task automatic test_flush_priority();
        flush     = 1'b1;
        flush_pc  = 32'hbfc00380;
        br_valid  = 1'b1;
        br_target = 32'hbfc00100;
        @(negedge clk);
        checks++;
        if ({inst_sram_en, id_valid} !== 2'b00) begin
            fails++; $display("FAIL fl_cycle: en/valid %b, expected 00", {inst_sram_en, id_valid});
        end
        step();
        flush    = 1'b0;
        br_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00380) begin
            fails++; $display("FAIL fl_req: en %b addr %h, expected 1 bfc00380", inst_sram_en, inst_sram_addr);
        end
        step(); step(); @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hbfc00380) begin
            fails++; $display("FAIL fl_head: valid %b pc %h, expected 1 bfc00380", id_valid, id_pc);
        end
        repeat (4) step();
    endtask

    task automatic test_wrap();
        br_valid  = 1'b1;
        br_target = 32'hfffffffc;
        @(negedge clk);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hfffffffc) begin
            fails++; $display("FAIL wrap_a: en %b addr %h, expected 1 fffffffc", inst_sram_en, inst_sram_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h00000000) begin
            fails++; $display("FAIL wrap_b: en %b addr %h, expected 1 00000000", inst_sram_en, inst_sram_addr);
        end
        repeat (5) step();
    endtask

    task automatic test_mid_reset();
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b0) begin
            fails++; $display("FAIL mr_en: en %b, expected 0", inst_sram_en);
        end
        step(); @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || inst_sram_addr !== RVEC) begin
            fails++; $display("FAIL mr_state: valid %b pc %h addr %h, expected 0 0 %h", id_valid, id_pc, inst_sram_addr, RVEC);
        end
        step();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== RVEC) begin
            fails++; $display("FAIL mr_rel: en %b addr %h, expected 1 %h", inst_sram_en, inst_sram_addr, RVEC);
        end
        repeat (5) step();
    endtask

    task automatic test_misaligned();
`ifdef FETCH_ADEL_EN
        int n;
        br_valid  = 1'b1;
        br_target = 32'hbfc00002;
        id_ready  = 1'b0;
        @(negedge clk);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b0) begin
            fails++; $display("FAIL adel_noreq: en %b, expected 0", inst_sram_en);
        end
        step(); step(); @(negedge clk);
        checks++;
        if ({id_valid, id_adel} !== 2'b11 || id_pc !== 32'hbfc00002 || id_inst !== 32'h0) begin
            fails++; $display("FAIL adel_head: valid/adel %b pc %h inst %h, expected 11 bfc00002 0",
                              {id_valid, id_adel}, id_pc, id_inst);
        end
        n = 0;
        repeat (5) begin
            step(); @(negedge clk);
            if (inst_sram_en) n++;
        end
        checks++;
        if (n != 0) begin
            fails++; $display("FAIL adel_halt: %0d requests while halted, expected 0", n);
        end
        step();
        flush    = 1'b1;
        flush_pc = 32'hbfc00380;
        @(negedge clk);
        step();
        flush    = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00380) begin
            fails++; $display("FAIL adel_resume: en %b addr %h, expected 1 bfc00380", inst_sram_en, inst_sram_addr);
        end
        repeat (6) step();
`else
        br_valid  = 1'b1;
        br_target = 32'hbfc00002;
        id_ready  = 1'b1;
        @(negedge clk);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00002) begin
            fails++; $display("FAIL mis_req: en %b addr %h, expected 1 bfc00002", inst_sram_en, inst_sram_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00006) begin
            fails++; $display("FAIL mis_next: en %b addr %h, expected 1 bfc00006", inst_sram_en, inst_sram_addr);
        end
        step(); @(negedge clk);
        checks++;
        if ({id_valid, id_adel} !== 2'b10 || id_pc !== 32'hbfc00002) begin
            fails++; $display("FAIL mis_head: valid/adel %b pc %h, expected 10 bfc00002", {id_valid, id_adel}, id_pc);
        end
        repeat (4) step();
`endif
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_branch();
        test_flush_priority();
        test_wrap();
        test_mid_reset();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
